// File: rtl/tilelink_router_pkg.sv
// Shared TileLink-UL channel payloads, opcodes and router helpers.
package tilelink_router_pkg;

  localparam int unsigned TL_AW   = 32;
  localparam int unsigned TL_DW   = 32;
  localparam int unsigned TL_MW   = TL_DW / 8;
  localparam int unsigned TL_SRCW = 8;
  localparam int unsigned TL_SZW  = 2;

  localparam logic [2:0] TL_OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_OP_GET         = 3'd4;
  localparam logic [2:0] TL_OP_ACK         = 3'd0;
  localparam logic [2:0] TL_OP_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic               a_valid;
    logic [2:0]         a_opcode;
    logic [2:0]         a_param;
    logic [TL_SZW-1:0]  a_size;
    logic [TL_SRCW-1:0] a_source;
    logic [TL_AW-1:0]   a_address;
    logic [TL_MW-1:0]   a_mask;
    logic [TL_DW-1:0]   a_data;
  } tilelink_a;

  typedef struct packed {
    logic               d_valid;
    logic [2:0]         d_opcode;
    logic [2:0]         d_param;
    logic [TL_SZW-1:0]  d_size;
    logic [TL_SRCW-1:0] d_source;
    logic               d_sink;
    logic [TL_DW-1:0]   d_data;
    logic               d_error;
  } tilelink_d;

  // Index width for a device count, never below one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Error reply to a request: data-carrying ack for Get, plain ack otherwise.
  function automatic tilelink_d error_resp(logic [2:0] a_opcode, logic [TL_SZW-1:0] a_size,
                                           logic [TL_SRCW-1:0] a_source);
    tilelink_d r;
    r          = '0;
    r.d_valid  = 1'b1;
    r.d_opcode = (a_opcode == TL_OP_GET) ? TL_OP_ACK_DATA : TL_OP_ACK;
    r.d_size   = a_size;
    r.d_source = a_source;
    r.d_error  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tilelink_router_if.sv
// Host and device-side TileLink-UL channels of the router.
interface tilelink_router_if #(
  parameter int unsigned NUM_DEV = 3
) ();
  import tilelink_router_pkg::*;

  tilelink_a                host_tla;
  logic                     host_a_ready;
  tilelink_d                host_tld;
  logic                     host_d_ready;
  tilelink_a [NUM_DEV-1:0]  dev_tla;
  tilelink_d [NUM_DEV-1:0]  dev_tld;

  modport router (
    input  host_tla, host_d_ready, dev_tld,
    output host_a_ready, host_tld, dev_tla
  );

  modport env (
    output host_tla, host_d_ready, dev_tld,
    input  host_a_ready, host_tld, dev_tla
  );
endinterface

// File: rtl/tilelink_addr_decode.sv
// Mask/tag address decoder; the lowest-index matching device wins.
module tilelink_addr_decode
  import tilelink_router_pkg::*;
#(
  parameter int unsigned           NUM_DEV    = 3,
  parameter logic [NUM_DEV*32-1:0] ADDR_MASKS = {NUM_DEV{32'hF0000000}},
  parameter logic [NUM_DEV*32-1:0] ADDR_TAGS  = {32'hF0000000, 32'h80000000, 32'h00000000}
) (
  input  logic [TL_AW-1:0]                address,
  output logic                            hit,
  output logic [idx_width(NUM_DEV)-1:0]   index
);

  localparam int unsigned IDX_W = idx_width(NUM_DEV);

  // Scan downwards so the last (lowest-index) match is the one kept.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = int'(NUM_DEV) - 1; i >= 0; i--) begin
      if ((address & ADDR_MASKS[i*32 +: 32]) == ADDR_TAGS[i*32 +: 32]) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tilelink_router.sv
// 1-host to NUM_DEV-device TileLink-UL router, one transaction outstanding,
// with registered response, decode-miss/timeout errors and a stray-response counter.
module tilelink_router
  import tilelink_router_pkg::*;
#(
  parameter int unsigned           NUM_DEV    = 3,
  parameter logic [NUM_DEV*32-1:0] ADDR_MASKS = {NUM_DEV{32'hF0000000}},
  parameter logic [NUM_DEV*32-1:0] ADDR_TAGS  = {32'hF0000000, 32'h80000000, 32'h00000000},
  parameter int unsigned           TIMEOUT    = 16,
  parameter int unsigned           CNT_W      = 8
) (
  input  logic               clock,
  input  logic               reset_in,
  tilelink_router_if.router  bus,
  output logic [CNT_W-1:0]   stray_count
);

  localparam int unsigned IDX_W = idx_width(NUM_DEV);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [2:0]         op_q, op_d;
  logic [TL_SRCW-1:0] src_q, src_d;
  logic [TL_SZW-1:0]  size_q, size_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  tilelink_d          tld_q, tld_d;
  logic [CNT_W-1:0]   stray_q, stray_d;
  logic               a_ready_q;

  logic                    hit_c;
  logic [IDX_W-1:0]        idx_c;
  logic                    accept_c;
  tilelink_d               rsp_sel_c;
  logic [NUM_DEV-1:0]      stray_hit_c;
  tilelink_a [NUM_DEV-1:0] dev_tla_c;

  tilelink_addr_decode #(
    .NUM_DEV    (NUM_DEV),
    .ADDR_MASKS (ADDR_MASKS),
    .ADDR_TAGS  (ADDR_TAGS)
  ) u_decode (
    .address (bus.host_tla.a_address),
    .hit     (hit_c),
    .index   (idx_c)
  );

  assign accept_c  = !reset_in && (state_q == IDLE) && bus.host_tla.a_valid;
  assign rsp_sel_c = bus.dev_tld[sel_q];

  // Request fan-out: payload is broadcast, only the decoded device sees a_valid.
  always_comb begin
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      dev_tla_c[i]         = bus.host_tla;
      dev_tla_c[i].a_valid = accept_c && hit_c && (idx_c == IDX_W'(i));
    end
  end

  // Only the selected device while waiting may answer; anything else is stray.
  always_comb begin
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      stray_hit_c[i] = bus.dev_tld[i].d_valid && !((state_q == WAIT) && (sel_q == IDX_W'(i)));
    end
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      op_q      <= '0;
      src_q     <= '0;
      size_q    <= '0;
      timer_q   <= '0;
      tld_q     <= '0;
      stray_q   <= '0;
      a_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      op_q      <= op_d;
      src_q     <= src_d;
      size_q    <= size_d;
      timer_q   <= timer_d;
      tld_q     <= tld_d;
      stray_q   <= stray_d;
      a_ready_q <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_d    = op_q;
    src_d   = src_q;
    size_d  = size_q;
    timer_d = timer_q;
    tld_d   = tld_q;
    stray_d = stray_q;

    if (|stray_hit_c && !(&stray_q)) stray_d = stray_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d   = bus.host_tla.a_opcode;
          src_d  = bus.host_tla.a_source;
          size_d = bus.host_tla.a_size;
          if (hit_c) begin
            sel_d   = idx_c;
            timer_d = '0;
            state_d = WAIT;
          end else begin
            tld_d   = error_resp(bus.host_tla.a_opcode, bus.host_tla.a_size, bus.host_tla.a_source);
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        // A device reply in the expiry cycle still beats the timeout.
        if (rsp_sel_c.d_valid) begin
          tld_d   = rsp_sel_c;
          state_d = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
            tld_d   = error_resp(op_q, size_q, src_q);
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.host_d_ready) begin
          tld_d.d_valid = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.host_a_ready = a_ready_q;
  assign bus.host_tld     = tld_q;
  assign bus.dev_tla      = dev_tla_c;
  assign stray_count      = stray_q;

endmodule
